vector_scalar_divider: RTL and testbench
========================================

# vector_scalar_divider

Sequential, parametrised divider of a `NUM_LANES`-element integer vector by one shared scalar divisor. Replaces the combinational per-neuron divider used in layer normalisation/averaging with a radix-2 iterative datapath, one restoring divider per lane. Takes one operand set per valid/ready transfer and returns the quotient vector plus status flags. Sits between the accumulate stage and the activation stage of the feed-forward pipeline.

## Interface
Parameters:
- `NUM_LANES`, default `MAX_NEURONS` (library value): vector elements, all processed in parallel.
- `DATA_W`, default 32: width of each element, the divisor, and each quotient.
- `SIGNED`, default 1: 1 = two's-complement operands, 0 = unsigned.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand set valid.
- `in_ready` out 1: block can accept operands.
- `vec_in` in `NUM_LANES*DATA_W`: dividends, lane i at bits [i*DATA_W +: DATA_W].
- `scalar_in` in `DATA_W`: divisor.
- `out_valid` out 1: quotient vector valid.
- `out_ready` in 1: consumer accepts result.
- `vec_out` out `NUM_LANES*DATA_W`: quotients, same packing as `vec_in`.
- `div_by_zero` out 1: result was produced with divisor 0.
- `overflow` out `NUM_LANES`: per-lane saturation (signed MIN / -1).

## Operation
- States: IDLE, DIVIDE, DONE. `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- IDLE: on `in_valid && in_ready`, register operands.
  - If divisor = 0, go to DONE.
  - Otherwise go to DIVIDE with the iteration counter set to `DATA_W-1`.
- Load: when `SIGNED`=1, take magnitudes of each dividend and the divisor; latch each lane's result sign (dividend sign XOR divisor sign). When `SIGNED`=0, use raw values.
- DIVIDE: each cycle, every lane does one restoring step:
  - shift remainder left by one, bringing in the next dividend MSB;
  - subtract the divisor magnitude; if the result is non-negative, keep it and set the quotient bit to 1, else set the quotient bit to 0.
  - Remainder register is `DATA_W+1` bits.
  - When the counter reaches 0, apply sign (negate the quotient when the lane sign is 1), register `vec_out`/`overflow`, and go to DONE.
- Rounding: truncation toward zero, matching SystemVerilog integer `/`. The remainder is discarded.
- Divide by zero: `div_by_zero`=1. Each lane saturates: unsigned gives all-ones; signed gives +MAX when the dividend is ≥ 0 and MIN when it is < 0. `overflow` = 0.
- Signed MIN / -1: that lane gives +MAX (2^(DATA_W-1)-1) and its `overflow` bit = 1. Other lanes are unaffected.
- DONE: hold `vec_out`, `div_by_zero` and `overflow` stable until `out_ready`=1, then go to IDLE.
  - Outputs keep their last values in IDLE and are overwritten only by the next result.
  - No accept is possible in DONE, so a new operand set cannot overlap a pending result.
- `in_valid` is ignored outside IDLE. Operand inputs may change freely after acceptance.

## Timing
- Reset values (async assert, sync deassert handled upstream): state IDLE, `in_ready`=1, `out_valid`=0, `vec_out`=0, `div_by_zero`=0, `overflow`=0, counter 0.
- Latency, nonzero divisor: accepted at edge k gives `out_valid`=1 after edge k+`DATA_W`+1 (33 cycles at `DATA_W`=32).
- Latency, zero divisor: `out_valid`=1 after edge k+1.
- Throughput: one vector per `DATA_W`+2 cycles when `out_ready` is tied high (accept, `DATA_W` DIVIDE cycles, DONE with handshake). `in_ready` returns high the cycle after the output handshake.
- Reset mid-operation: immediate return to the reset values; the partial result is discarded and no `out_valid` pulse occurs.
- Back-pressure: `out_valid` stays high with stable data for any number of cycles with `out_ready`=0.

## Test plan
- `DATA_W`=8, `SIGNED`=1, `NUM_LANES`=4, vec {100, -100, 7, -7}, scalar 7 -> {14, -14, 1, -1}, flags 0, `out_valid` 9 cycles after accept.
- Same config, vec {-128, 127, 0, 5}, scalar -1 -> {127, -127, 0, -5}, `overflow`=4'b0001.
- Divisor 0, vec {5, -5, 0, 1} -> {127, -128, 127, 127}, `div_by_zero`=1, `out_valid` 1 cycle after accept.
- `SIGNED`=0, vec {255, 200, 3, 0}, scalar 16 -> {15, 12, 0, 0}; with scalar 0 -> all 255.
- Hold `out_ready`=0 for 20 cycles: outputs stable, `in_ready`=0, a pulse on `in_valid` is ignored. Release -> one transfer, then the next accept proceeds.
- Assert `rst_n`=0 at DIVIDE cycle 3 -> `out_valid` stays 0, `in_ready`=1 after release. A fresh operation then completes correctly.

Source files
------------

// File: rtl/vector_scalar_divider.sv
// ============================================================================
// Module   : vector_scalar_divider
// Brief    : Iterative radix-2 restoring divider of a lane vector by a shared
//            scalar, one divider per lane, valid/ready in and out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nn_lib_pkg;
    localparam int MAX_NEURONS = 16;
endpackage

module vector_scalar_divider #(
    parameter int NUM_LANES = nn_lib_pkg::MAX_NEURONS,
    parameter int DATA_W    = 32,
    parameter bit SIGNED    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_LANES*DATA_W-1:0]   vec_in,
    input  logic [DATA_W-1:0]             scalar_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LANES*DATA_W-1:0]   vec_out,
    output logic                          div_by_zero,
    output logic [NUM_LANES-1:0]          overflow
);

    localparam int c_CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [DATA_W-1:0] c_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] c_ONES = {DATA_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                          r_state;
    logic [c_CNT_W-1:0]              r_cnt;
    logic [DATA_W-1:0]               r_dsr;
    logic [DATA_W-1:0]               r_dvd [NUM_LANES];
    logic [DATA_W:0]                 r_rem [NUM_LANES];
    // Only the low DATA_W-1 quotient bits need storing; the final bit is
    // produced combinationally on the last step.
    logic [DATA_W-2:0]               r_quo [NUM_LANES];
    logic [NUM_LANES-1:0]            r_neg;
    logic                            r_in_ready;
    logic                            r_out_valid;
    logic [NUM_LANES*DATA_W-1:0]     r_vec_out;
    logic                            r_dbz;
    logic [NUM_LANES-1:0]            r_ovf;

    logic [DATA_W-1:0]               w_dsr_mag;
    logic [DATA_W-1:0]               w_mag     [NUM_LANES];
    logic [NUM_LANES-1:0]            w_neg_in;
    logic [DATA_W:0]                 w_rem_nxt [NUM_LANES];
    logic [DATA_W-1:0]               w_quo_nxt [NUM_LANES];
    logic [NUM_LANES*DATA_W-1:0]     w_res_vec;
    logic [NUM_LANES*DATA_W-1:0]     w_dbz_vec;
    logic [NUM_LANES-1:0]            w_sat;

    assign w_dsr_mag = (SIGNED && scalar_in[DATA_W-1]) ? -scalar_in : scalar_in;

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            logic [DATA_W-1:0] w_lane_in;
            logic [DATA_W+1:0] w_shift;
            logic [DATA_W+1:0] w_diff;
            logic              w_ge;

            assign w_lane_in   = vec_in[i*DATA_W +: DATA_W];
            assign w_mag[i]    = (SIGNED && w_lane_in[DATA_W-1]) ? -w_lane_in : w_lane_in;
            assign w_neg_in[i] = SIGNED && (w_lane_in[DATA_W-1] ^ scalar_in[DATA_W-1]);

            // Remainder stays below the divisor, so the top shifted bit is
            // zero and the sign of the difference is exact.
            assign w_shift      = {r_rem[i], r_dvd[i][DATA_W-1]};
            assign w_diff       = w_shift - {2'b00, r_dsr};
            assign w_ge         = ~w_diff[DATA_W+1];
            assign w_rem_nxt[i] = w_ge ? w_diff[DATA_W:0] : w_shift[DATA_W:0];
            assign w_quo_nxt[i] = {r_quo[i], w_ge};

            // A positive result with the MSB set only arises from MIN / -1.
            assign w_sat[i] = SIGNED && !r_neg[i] && w_quo_nxt[i][DATA_W-1];
            assign w_res_vec[i*DATA_W +: DATA_W] =
                w_sat[i] ? c_MAX : (r_neg[i] ? -w_quo_nxt[i] : w_quo_nxt[i]);

            assign w_dbz_vec[i*DATA_W +: DATA_W] =
                !SIGNED ? c_ONES : (w_lane_in[DATA_W-1] ? c_MIN : c_MAX);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dsr       <= '0;
            r_neg       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_vec_out   <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                r_dvd[l] <= '0;
                r_rem[l] <= '0;
                r_quo[l] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_dsr      <= w_dsr_mag;
                        r_neg      <= w_neg_in;
                        r_in_ready <= 1'b0;
                        for (int l = 0; l < NUM_LANES; l++) begin
                            r_dvd[l] <= w_mag[l];
                            r_rem[l] <= '0;
                            r_quo[l] <= '0;
                        end
                        if (scalar_in == '0) begin
                            r_vec_out   <= w_dbz_vec;
                            r_dbz       <= 1'b1;
                            r_ovf       <= '0;
                            r_out_valid <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= S_DONE;
                        end else begin
                            r_cnt   <= c_CNT_W'(DATA_W - 1);
                            r_state <= S_DIVIDE;
                        end
                    end
                end
                S_DIVIDE: begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        r_dvd[l] <= {r_dvd[l][DATA_W-2:0], 1'b0};
                        r_rem[l] <= w_rem_nxt[l];
                        r_quo[l] <= w_quo_nxt[l][DATA_W-2:0];
                    end
                    if (r_cnt == '0) begin
                        r_vec_out   <= w_res_vec;
                        r_ovf       <= w_sat;
                        r_dbz       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign vec_out     = r_vec_out;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_vector_scalar_divider.sv
// ============================================================================
// Module   : tb_vector_scalar_divider
// Brief    : Directed self-checking bench, 4 lanes x 8 bits, signed and
//            unsigned instances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_scalar_divider;

    localparam int DW = 8;
    localparam int NL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic [NL*DW-1:0] s_vec_in = '0;
    logic [DW-1:0]    s_scalar = '0;
    logic             s_in_ready, s_out_valid, s_dbz;
    logic [NL*DW-1:0] s_vec_out;
    logic [NL-1:0]    s_ovf;

    logic             u_in_valid = 1'b0, u_out_ready = 1'b0;
    logic [NL*DW-1:0] u_vec_in = '0;
    logic [DW-1:0]    u_scalar = '0;
    logic             u_in_ready, u_out_valid, u_dbz;
    logic [NL*DW-1:0] u_vec_out;
    logic [NL-1:0]    u_ovf;

    vector_scalar_divider #(.NUM_LANES(NL), .DATA_W(DW), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .vec_in(s_vec_in), .scalar_in(s_scalar),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .vec_out(s_vec_out), .div_by_zero(s_dbz), .overflow(s_ovf)
    );

    vector_scalar_divider #(.NUM_LANES(NL), .DATA_W(DW), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n),
        .in_valid(u_in_valid), .in_ready(u_in_ready),
        .vec_in(u_vec_in), .scalar_in(u_scalar),
        .out_valid(u_out_valid), .out_ready(u_out_ready),
        .vec_out(u_vec_out), .div_by_zero(u_dbz), .overflow(u_ovf)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NL*DW-1:0] pk(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic send(input bit u, input logic [NL*DW-1:0] v, input logic [DW-1:0] d);
        int t = 0;
        @(negedge clk);
        while (!(u ? u_in_ready : s_in_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("in_ready_timeout", 64'd0, 64'd1);
        if (u) begin u_in_valid = 1'b1; u_vec_in = v; u_scalar = d; end
        else   begin s_in_valid = 1'b1; s_vec_in = v; s_scalar = d; end
        @(posedge clk);
        #1;
        s_in_valid = 1'b0; u_in_valid = 1'b0;
        s_vec_in = ~v; u_vec_in = ~v; s_scalar = 8'h5A; u_scalar = 8'h5A;
    endtask

    task automatic expect_out(input bit u, input string tag, input int lat_exp,
                              input logic [NL*DW-1:0] v_exp, input logic dbz_exp,
                              input logic [NL-1:0] ovf_exp);
        int lat = 1;
        while (!(u ? u_out_valid : s_out_valid) && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(lat_exp));
        chk({tag, "_vec"}, u ? u_vec_out : s_vec_out, v_exp);
        chk({tag, "_dbz"}, u ? u_dbz : s_dbz, dbz_exp);
        chk({tag, "_ovf"}, u ? u_ovf : s_ovf, ovf_exp);
    endtask

    task automatic take(input bit u, input string tag);
        @(negedge clk);
        if (u) u_out_ready = 1'b1; else s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        u_out_ready = 1'b0; s_out_ready = 1'b0;
        chk({tag, "_ov_drop"}, u ? u_out_valid : s_out_valid, 1'b0);
        chk({tag, "_rdy_back"}, u ? u_in_ready : s_in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        logic seen;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", s_in_ready, 1'b1);
        chk("rst_out_valid", s_out_valid, 1'b0);
        chk("rst_vec_out", s_vec_out, '0);
        chk("rst_dbz", s_dbz, 1'b0);
        chk("rst_ovf", s_ovf, '0);
        chk("rst_u_in_ready", u_in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        send(0, pk(8'h64, 8'h9C, 8'h07, 8'hF9), 8'h07);
        expect_out(0, "div7", 9, pk(8'h0E, 8'hF2, 8'h01, 8'hFF), 1'b0, 4'b0000);
        take(0, "div7");

        send(0, pk(8'h05, 8'hFB, 8'h00, 8'h01), 8'h00);
        expect_out(0, "dz_s", 1, pk(8'h7F, 8'h80, 8'h7F, 8'h7F), 1'b1, 4'b0000);
        take(0, "dz_s");

        send(0, pk(8'h80, 8'h7F, 8'h00, 8'h05), 8'hFF);
        expect_out(0, "neg1", 9, pk(8'h7F, 8'h81, 8'h00, 8'hFB), 1'b0, 4'b0001);
        take(0, "neg1");

        send(0, pk(8'h80, 8'h7F, 8'h80, 8'hF9), 8'h02);
        expect_out(0, "div2", 9, pk(8'hC0, 8'h3F, 8'hC0, 8'hFD), 1'b0, 4'b0000);
        take(0, "div2");

        send(0, pk(8'h80, 8'h7F, 8'h00, 8'hFF), 8'h80);
        expect_out(0, "divmin", 9, pk(8'h01, 8'h00, 8'h00, 8'h00), 1'b0, 4'b0000);
        take(0, "divmin");

        send(1, pk(8'hFF, 8'hC8, 8'h03, 8'h00), 8'h10);
        expect_out(1, "u16", 9, pk(8'h0F, 8'h0C, 8'h00, 8'h00), 1'b0, 4'b0000);
        take(1, "u16");

        send(1, pk(8'hFF, 8'hC8, 8'h03, 8'h00), 8'h00);
        expect_out(1, "dz_u", 1, pk(8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b1, 4'b0000);
        take(1, "dz_u");

        // Back-pressure with an in_valid pulse that must be ignored.
        send(0, pk(8'h64, 8'h9C, 8'h07, 8'hF9), 8'h07);
        expect_out(0, "bp", 9, pk(8'h0E, 8'hF2, 8'h01, 8'hFF), 1'b0, 4'b0000);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) begin
                s_in_valid = 1'b1;
                s_vec_in   = pk(8'h11, 8'h22, 8'h33, 8'h44);
                s_scalar   = 8'h00;
            end
            if (i == 7) s_in_valid = 1'b0;
            if (!s_out_valid || s_in_ready || s_dbz ||
                s_vec_out !== pk(8'h0E, 8'hF2, 8'h01, 8'hFF)) ok = 1'b0;
        end
        chk("bp_hold", ok, 1'b1);
        take(0, "bp");
        send(0, pk(8'h80, 8'h7F, 8'h00, 8'hFF), 8'h80);
        expect_out(0, "after_bp", 9, pk(8'h01, 8'h00, 8'h00, 8'h00), 1'b0, 4'b0000);
        take(0, "after_bp");

        // Reset during the third DIVIDE cycle.
        send(0, pk(8'h64, 8'h9C, 8'h07, 8'hF9), 8'h07);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", s_out_valid, 1'b0);
        chk("mid_rst_rdy", s_in_ready, 1'b1);
        chk("mid_rst_vec", s_vec_out, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen = seen | s_out_valid;
        end
        chk("mid_rst_no_pulse", seen, 1'b0);
        chk("mid_rst_rdy_after", s_in_ready, 1'b1);
        send(0, pk(8'h80, 8'h7F, 8'h00, 8'h05), 8'hFF);
        expect_out(0, "post_rst", 9, pk(8'h7F, 8'h81, 8'h00, 8'hFB), 1'b0, 4'b0001);
        take(0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
